pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the pipelined core: holds the fetch PC, applies redirects (branch/jump, call/return, interrupt entry, interrupt return), and carries PC+1 down a configurable number of pipeline taps with valid bits. A small return-address stack (RAS) supplies return targets, and an EPC register supports one level of interrupt. It sits in the fetch stage, addressing instruction memory and feeding the branch and JAL logic downstream.

## Interface
- PC_W, 32, PC and address width
- RESET_VEC, 0, PC value loaded on reset
- INT_VEC, 'h100, PC loaded on interrupt entry
- PIPE_STAGES, 3, number of PC+1 taps (min 2): tap0=IM_ID, tap1=ID_EX, tap2=EX_DM, …
- RAS_DEPTH, 4, return-address stack entries (power of 2, min 2)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  freezes PC, tap0 and all redirect acceptance
- flow_change  in  1  taken branch/jump resolved in EX
- dst  in  PC_W  redirect target for flow_change
- call  in  1  qualifies flow_change as call: push return address
- ret  in  1  qualifies flow_change as return: target from RAS
- int_req  in  1  level interrupt request, held until int_ack
- reti  in  1  return from interrupt
- pc  out  PC_W  fetch address
- pc_tap  out  PIPE_STAGES*PC_W  flattened taps, tap k at [k*PC_W +: PC_W]
- tap_vld  out  PIPE_STAGES  per-tap valid
- epc  out  PC_W  saved interrupt return PC
- int_active  out  1  interrupt in service
- int_ack  out  1  one-cycle pulse on interrupt acceptance
- ras_empty  out  1  RAS holds no entries

## Operation
- nxt_pc = pc + 1, modulo 2^PC_W (wraps all-ones → 0).
- Per cycle with stall=0, priority highest first: (1) int_req & !int_active: pc←INT_VEC, epc←pc, int_active←1, int_ack←1; (2) reti: pc←epc, int_active←0; (3) flow_change: pc←(ret & !ras_empty) ? RAS top : dst; (4) else pc←nxt_pc.
- int_req while int_active is ignored (no nesting); reti while !int_active still loads epc.
- Lower-priority events coinciding with a higher one are dropped, including RAS push/pop.
- stall=1: pc, epc, int_active, tap0, tap_vld[0] and RAS hold; int_ack=0; all redirects ignored (the requester must hold them).
- tap0 ← nxt_pc, tap_vld[0] ← 1 when !stall and no redirect accepted; on an accepted redirect tap_vld[0] ← 0 and tap_vld[1] ← 0 (wrong-path flush).
- Taps k≥1 always advance: pc_tap[k] ← pc_tap[k-1], tap_vld[k] ← tap_vld[k-1] (except the tap1 flush above).
- RAS, on accepted flow_change only: call pushes pc_tap[1]; ret pops. call & ret together: pop then push (top replaced, count unchanged).
- Push when full: wraps, overwrites oldest, count saturates at RAS_DEPTH. Pop when empty: target = dst, count stays 0.

## Timing
- Reset (async assert, sync release): pc=RESET_VEC; pc_tap=0; tap_vld=0; epc=0; int_active=0; int_ack=0; RAS pointer/count=0; ras_empty=1.
- Redirect accepted in cycle n → new pc visible in cycle n+1; tap k reflects the instruction fetched at n+k.
- int_ack asserts in the cycle after acceptance, for exactly one cycle.
- Reset mid-operation discards the RAS contents and the interrupt state immediately.

## Structure
- Shared package pc_pkg: redirect cause enum (NONE, INT, RETI, FLOW, SEQ) and default vector constants.
- One sub-module: pc_ras (circular stack: push/pop/top/empty, count saturation).

## Test plan
- Reset, then 5 free cycles → pc 0..5; tap0 lags pc by one cycle as PC+1; tap_vld fills one stage per cycle.
- stall for 3 cycles at pc=4 → pc and tap0 hold at 4/4; taps ≥1 keep shifting; resume gives pc=5.
- flow_change with dst=0x40 at pc=7 → pc=0x40 next cycle; tap_vld[0] and tap_vld[1] cleared.
- call at tap1=0x11 with dst=0x80, then ret with dst=0xDEAD → pc=0x11. Five pushes with RAS_DEPTH=4, then five rets → first four pops return the last four pushed; the fifth returns dst; ras_empty=1.
- int_req at pc=0x20 → pc=0x100, epc=0x20, int_ack one cycle; second int_req ignored; reti → pc=0x20, int_active=0.
- int_req + flow_change in the same cycle → interrupt wins, no RAS push; rst asserted mid-interrupt → pc=RESET_VEC, int_active=0 asynchronously.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default vectors for the program-counter generator
// Contents:
//   cause_e          redirect cause chosen for the current cycle
//   DEF_RESET_VEC    default PC loaded on reset
//   DEF_INT_VEC      default PC loaded on interrupt entry
package pc_pkg;

    typedef enum logic [2:0] {
        CAUSE_NONE,     // stalled: nothing advances in the fetch stage
        CAUSE_INT,      // interrupt entry
        CAUSE_RETI,     // return from interrupt
        CAUSE_FLOW,     // branch/jump/call/return resolved in EX
        CAUSE_SEQ       // sequential fetch
    } cause_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_INT_VEC   = 32'h0000_0100;

endpackage

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch-control bundle between pipeline control and the PC generator
// Signals:
//   stall, flow_change, dst, call, ret, int_req, reti   requests from pipeline control
//   pc, pc_tap, tap_vld, epc, int_active, int_ack,
//   ras_empty                                          state reported by the PC generator
// Modports: master = pipeline control side, slave = PC generator side.
interface pc_gen_if #(
    parameter int PC_W        = 32,
    parameter int PIPE_STAGES = 3
);
    logic                        stall;
    logic                        flow_change;
    logic [PC_W-1:0]             dst;
    logic                        call;
    logic                        ret;
    logic                        int_req;
    logic                        reti;

    logic [PC_W-1:0]             pc;
    logic [PIPE_STAGES*PC_W-1:0] pc_tap;
    logic [PIPE_STAGES-1:0]      tap_vld;
    logic [PC_W-1:0]             epc;
    logic                        int_active;
    logic                        int_ack;
    logic                        ras_empty;

    modport master (
        output stall, flow_change, dst, call, ret, int_req, reti,
        input  pc, pc_tap, tap_vld, epc, int_active, int_ack, ras_empty
    );

    modport slave (
        input  stall, flow_change, dst, call, ret, int_req, reti,
        output pc, pc_tap, tap_vld, epc, int_active, int_ack, ras_empty
    );
endinterface

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with saturating occupancy count
// Ports:
//   clk, rst      clock, asynchronous active-high reset (clears pointer and count)
//   push, pop     stack operations; both together replace the top entry
//   push_data     return address to push
//   top           current top-of-stack entry
//   empty         no entries held
module pc_ras #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PC_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W:0]   count;
    logic             do_pop;

    assign top_ptr = wptr - PTR_W'(1);
    assign top     = mem[top_ptr];
    assign empty   = (count == '0);
    // Popping an empty stack is a no-op; the caller falls back to its own target.
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            count <= '0;
        end else if (push && do_pop) begin
            // pop-then-push: the top slot is rewritten, pointer and count unchanged
            wptr  <= wptr;
        end else if (push) begin
            // When full, wptr already points at the oldest entry, so it is overwritten.
            wptr <= wptr + PTR_W'(1);
            if (count != (PTR_W+1)'(DEPTH))
                count <= count + (PTR_W+1)'(1);
        end else if (do_pop) begin
            wptr  <= top_ptr;
            count <= count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[(push && do_pop) ? top_ptr : wptr] <= push_data;
    end
endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program counter with redirects, return-address stack, EPC and PC+1 taps
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        pc_gen_if.slave: requests (stall, flow_change, dst, call, ret, int_req, reti)
//              and state (pc, pc_tap, tap_vld, epc, int_active, int_ack, ras_empty)
module pc_gen
    import pc_pkg::*;
#(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] RESET_VEC   = PC_W'(DEF_RESET_VEC),
    parameter logic [PC_W-1:0] INT_VEC     = PC_W'(DEF_INT_VEC),
    parameter int              PIPE_STAGES = 3,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);
    logic [PC_W-1:0]        pc;
    logic [PC_W-1:0]        epc;
    logic                   int_act;
    logic                   int_ack;
    logic [PC_W-1:0]        tap [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] tap_vld;

    logic [PC_W-1:0]        nxt_pc;
    logic [PC_W-1:0]        flow_tgt;
    logic [PC_W-1:0]        ras_top;
    logic                   ras_empty;
    logic                   ras_push;
    logic                   ras_pop;
    logic                   redirect;
    cause_e                 cause;

    assign nxt_pc = pc + PC_W'(1);

    always_comb begin
        cause = CAUSE_SEQ;
        if (bus.stall)
            cause = CAUSE_NONE;
        else if (bus.int_req && !int_act)
            cause = CAUSE_INT;
        else if (bus.reti)
            cause = CAUSE_RETI;
        else if (bus.flow_change)
            cause = CAUSE_FLOW;
    end

    assign redirect = (cause == CAUSE_INT) || (cause == CAUSE_RETI) || (cause == CAUSE_FLOW);
    // RAS only moves when the flow change itself is the accepted redirect.
    assign ras_push = (cause == CAUSE_FLOW) && bus.call;
    assign ras_pop  = (cause == CAUSE_FLOW) && bus.ret;
    assign flow_tgt = (bus.ret && !ras_empty) ? ras_top : bus.dst;

    pc_ras #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (tap[1]),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_VEC;
            epc     <= '0;
            int_act <= 1'b0;
            int_ack <= 1'b0;
            tap_vld <= '0;
            for (int k = 0; k < PIPE_STAGES; k++)
                tap[k] <= '0;
        end else begin
            int_ack <= (cause == CAUSE_INT);
            case (cause)
                CAUSE_INT: begin
                    pc      <= INT_VEC;
                    epc     <= pc;
                    int_act <= 1'b1;
                end
                CAUSE_RETI: begin
                    pc      <= epc;
                    int_act <= 1'b0;
                end
                CAUSE_FLOW: pc <= flow_tgt;
                CAUSE_SEQ:  pc <= nxt_pc;
                default:    pc <= pc;
            endcase

            if (!bus.stall) begin
                tap[0]     <= nxt_pc;
                tap_vld[0] <= !redirect;
            end
            // Downstream taps keep draining even while fetch is stalled.
            for (int k = 1; k < PIPE_STAGES; k++) begin
                tap[k]     <= tap[k-1];
                tap_vld[k] <= tap_vld[k-1];
            end
            // The instruction in IM_ID is on the wrong path as well.
            if (redirect)
                tap_vld[1] <= 1'b0;
        end
    end

    assign bus.pc         = pc;
    assign bus.epc        = epc;
    assign bus.int_active = int_act;
    assign bus.int_ack    = int_ack;
    assign bus.tap_vld    = tap_vld;
    assign bus.ras_empty  = ras_empty;

    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_tap
        assign bus.pc_tap[g*PC_W +: PC_W] = tap[g];
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;
    import pc_pkg::*;

    localparam int PC_W = 32;
    localparam int NS   = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pc_gen_if #(.PC_W(PC_W), .PIPE_STAGES(NS)) bus ();

    pc_gen #(
        .PC_W        (PC_W),
        .RESET_VEC   (32'h0),
        .INT_VEC     (32'h100),
        .PIPE_STAGES (NS),
        .RAS_DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] tap(input int k);
        logic [NS*PC_W-1:0] t;
        t = bus.pc_tap;
        return t[k*PC_W +: PC_W];
    endfunction

    task automatic clear_req();
        bus.stall       = 1'b0;
        bus.flow_change = 1'b0;
        bus.dst         = '0;
        bus.call        = 1'b0;
        bus.ret         = 1'b0;
        bus.int_req     = 1'b0;
        bus.reti        = 1'b0;
    endtask

    task automatic flow(input logic [31:0] d, input logic c, input logic r);
        bus.flow_change = 1'b1;
        bus.dst         = d;
        bus.call        = c;
        bus.ret         = r;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        clear_req();
        #2 rst = 1'b1;
        tick();
        tick();

        check("rst_pc",        bus.pc, 32'h0);
        check("rst_tap_vld",   32'(bus.tap_vld), 32'h0);
        check("rst_tap0",      tap(0), 32'h0);
        check("rst_epc",       bus.epc, 32'h0);
        check("rst_int_act",   32'(bus.int_active), 32'h0);
        check("rst_int_ack",   32'(bus.int_ack), 32'h0);
        check("rst_ras_empty", 32'(bus.ras_empty), 32'h1);

        rst = 1'b0;
        tick();
        check("seq1_pc",  bus.pc, 32'h1);
        check("seq1_tap0", tap(0), 32'h1);
        check("seq1_vld", 32'(bus.tap_vld), 32'h1);
        tick();
        check("seq2_pc",  bus.pc, 32'h2);
        check("seq2_tap1", tap(1), 32'h1);
        check("seq2_vld", 32'(bus.tap_vld), 32'h3);
        tick();
        check("seq3_vld", 32'(bus.tap_vld), 32'h7);
        check("seq3_tap2", tap(2), 32'h1);
        tick();
        check("seq4_pc",  bus.pc, 32'h4);

        // stall three cycles at pc=4
        bus.stall = 1'b1;
        tick();
        check("stall1_pc",   bus.pc, 32'h4);
        check("stall1_tap0", tap(0), 32'h4);
        check("stall1_tap2", tap(2), 32'h3);
        tick();
        tick();
        check("stall3_pc",   bus.pc, 32'h4);
        check("stall3_tap0", tap(0), 32'h4);
        check("stall3_tap2", tap(2), 32'h4);
        bus.stall = 1'b0;
        tick();
        check("resume_pc",   bus.pc, 32'h5);
        tick();
        tick();
        check("pre_flow_pc", bus.pc, 32'h7);

        // plain redirect with wrong-path flush
        flow(32'h40, 1'b0, 1'b0);
        tick();
        clear_req();
        check("flow_pc",      bus.pc, 32'h40);
        check("flow_vld",     32'(bus.tap_vld), 32'h4);
        tick();
        check("flow_pc1",     bus.pc, 32'h41);
        check("flow_vld1",    32'(bus.tap_vld), 32'h1);
        check("flow_tap1",    tap(1), 32'h8);

        // call at tap1=0x11, then ret
        flow(32'h10, 1'b0, 1'b0);
        tick();
        clear_req();
        tick();
        tick();
        check("call_tap1", tap(1), 32'h11);
        flow(32'h80, 1'b1, 1'b0);
        tick();
        check("call_pc",        bus.pc, 32'h80);
        check("call_ras_empty", 32'(bus.ras_empty), 32'h0);
        flow(32'hDEAD, 1'b0, 1'b1);
        tick();
        clear_req();
        check("ret_pc",        bus.pc, 32'h11);
        check("ret_ras_empty", 32'(bus.ras_empty), 32'h1);
        tick();
        tick();

        // five pushes into a four-deep stack; each call pushes previous dst+1
        check("push0_tap1", tap(1), 32'h12);
        for (int i = 0; i < 5; i++) begin
            flow(32'h200 + 32'(i) * 32'h100, 1'b1, 1'b0);
            tick();
            clear_req();
            tick();
            tick();
        end
        check("push5_ras_empty", 32'(bus.ras_empty), 32'h0);
        flow(32'hBAD, 1'b0, 1'b1);
        tick();
        check("pop1_pc", bus.pc, 32'h501);
        tick();
        check("pop2_pc", bus.pc, 32'h401);
        tick();
        check("pop3_pc", bus.pc, 32'h301);
        tick();
        check("pop4_pc", bus.pc, 32'h201);
        check("pop4_ras_empty", 32'(bus.ras_empty), 32'h1);
        tick();
        clear_req();
        check("pop5_pc", bus.pc, 32'hBAD);
        check("pop5_ras_empty", 32'(bus.ras_empty), 32'h1);

        // PC wraps all-ones to zero
        flow(32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        clear_req();
        check("wrap_hi", bus.pc, 32'hFFFF_FFFF);
        tick();
        check("wrap_lo", bus.pc, 32'h0);

        // interrupt entry, held request ignored, return
        flow(32'h20, 1'b0, 1'b0);
        tick();
        clear_req();
        bus.stall   = 1'b1;
        bus.int_req = 1'b1;
        tick();
        check("int_stall_pc",  bus.pc, 32'h20);
        check("int_stall_ack", 32'(bus.int_ack), 32'h0);
        check("int_stall_act", 32'(bus.int_active), 32'h0);
        bus.stall = 1'b0;
        tick();
        check("int_pc",  bus.pc, 32'h100);
        check("int_epc", bus.epc, 32'h20);
        check("int_ack", 32'(bus.int_ack), 32'h1);
        check("int_act", 32'(bus.int_active), 32'h1);
        tick();
        bus.int_req = 1'b0;
        check("int2_pc",  bus.pc, 32'h101);
        check("int2_ack", 32'(bus.int_ack), 32'h0);
        check("int2_epc", bus.epc, 32'h20);
        bus.reti = 1'b1;
        tick();
        clear_req();
        check("reti_pc",  bus.pc, 32'h20);
        check("reti_act", 32'(bus.int_active), 32'h0);

        // interrupt beats a coincident call; no RAS push
        flow(32'h500, 1'b1, 1'b0);
        bus.int_req = 1'b1;
        tick();
        clear_req();
        check("intflow_pc",    bus.pc, 32'h100);
        check("intflow_epc",   bus.epc, 32'h20);
        check("intflow_empty", 32'(bus.ras_empty), 32'h1);
        tick();
        check("intflow_pc1",   bus.pc, 32'h101);

        // asynchronous reset mid-interrupt
        #2 rst = 1'b1;
        #1;
        check("arst_pc",  bus.pc, 32'h0);
        check("arst_act", 32'(bus.int_active), 32'h0);
        check("arst_vld", 32'(bus.tap_vld), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_pc", bus.pc, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
